// File: rtl/pc_redirect_unit.sv
// Fetch-side PC owner: accepts jump/branch redirects, buffers one across a stall, and injects flush bubbles.
// Optional feature macro: REDIRECT_ALIGN_CHECK_EN (reject misaligned targets, sticky misalign_err).
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        redirect_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        pending
`ifdef REDIRECT_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] pend_target, pend_target_nxt;
  logic [AW-1:0] target_aligned;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          take;

  assign pc_plus4       = pc + AW'(4);
  assign target_aligned = redirect_target & ~AW'(3);

  // PEND is the only state that refuses new requests; nothing is acked in reset.
  assign redirect_ack = rst && redirect_valid && (state != PEND);
  assign fetch_valid  = rst && (state == RUN);

`ifdef REDIRECT_ALIGN_CHECK_EN
  logic target_bad;
  assign target_bad = |redirect_target[1:0];
  assign take       = redirect_ack && !target_bad;
`else
  assign take       = redirect_ack;
`endif

  // Next-state, next-PC and bubble counter.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    cnt_nxt         = cnt;
    pend_target_nxt = pend_target;
    case (state)
      RUN, FLUSH: begin
        if (take) begin
          if (stall) begin
            pend_target_nxt = target_aligned;
            state_nxt       = PEND;
          end else begin
            pc_nxt    = target_aligned;
            cnt_nxt   = CW'(FLUSH_CYCLES);
            state_nxt = FLUSH;
          end
        end else if (!stall) begin
          pc_nxt = pc_plus4;
          if (state == FLUSH) begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) state_nxt = RUN;
          end
        end
      end
      PEND: begin
        if (!stall) begin
          pc_nxt    = pend_target;
          cnt_nxt   = CW'(FLUSH_CYCLES);
          state_nxt = FLUSH;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      cnt         <= '0;
      pend_target <= '0;
      flush       <= 1'b0;
      pending     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      cnt         <= cnt_nxt;
      pend_target <= pend_target_nxt;
      flush       <= (state_nxt == FLUSH);
      pending     <= (state_nxt == PEND);
    end
  end

`ifdef REDIRECT_ALIGN_CHECK_EN
  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst)                          misalign_err <= 1'b0;
    else if (redirect_ack && target_bad) misalign_err <= 1'b1;
  end
`endif

endmodule
